// File: rtl/io_responder_if.sv
// Core-side handshake and board I/O bundle for io_responder.
// The slave modport belongs to the responder and the master modport to the core/board side.
interface io_responder_if;
  logic        in_req;
  logic        out_req;
  logic [31:0] out_data;
  logic        button;
  logic [15:0] switches;
  logic [31:0] in_data;
  logic        in_ack;
  logic        busy;
  logic [15:0] disp_value;
  logic [7:0]  out_count;

  modport slave (
    input  in_req, out_req, out_data, button, switches,
    output in_data, in_ack, busy, disp_value, out_count
  );

  modport master (
    output in_req, out_req, out_data, button, switches,
    input  in_data, in_ack, busy, disp_value, out_count
  );
endinterface

// File: rtl/io_responder.sv
// IN/OUT responder: a debounced check-in button completes an IN handshake with the
// current switch value, and OUT writes update a display register and a write counter.
module io_responder #(
  parameter int DEB_CYCLES = 4
) (
  input  logic Clock,
  input  logic n_reset,
  io_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ARM, WAIT_PRESS, ACK, DONE} state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        db_q, db_d;
  logic        db_prev_q, db_prev_d;
  logic [7:0]  deb_cnt_q, deb_cnt_d;
  logic [31:0] in_data_q, in_data_d;
  logic [15:0] disp_q, disp_d;
  logic [7:0]  out_count_q, out_count_d;
  logic        press;
  logic        unused_out_hi;

  assign unused_out_hi = ^bus.out_data[31:16];

  // Press is seen the cycle after the debounced level rises.
  assign press = db_q & ~db_prev_q;

  always_comb begin
    sync1_d   = bus.button;
    sync2_d   = sync1_q;
    db_prev_d = db_q;
    db_d      = db_q;
    deb_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        db_d = ~db_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    in_data_d = in_data_q;
    case (state_q)
      IDLE: begin
        if (bus.in_req) state_d = ARM;
      end
      ARM: begin
        // A button already held at request start must be released before it counts.
        if (!bus.in_req)  state_d = IDLE;
        else if (!db_q)   state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!bus.in_req) begin
          state_d = IDLE;
        end else if (press) begin
          state_d   = ACK;
          in_data_d = {{16{bus.switches[15]}}, bus.switches};
        end
      end
      ACK: begin
        state_d = DONE;
      end
      DONE: begin
        if (!bus.in_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    disp_d      = disp_q;
    out_count_d = out_count_q;
    if (bus.out_req) begin
      disp_d      = bus.out_data[15:0];
      out_count_d = out_count_q + 8'd1;
    end
  end

  always_ff @(posedge Clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      db_q        <= 1'b0;
      db_prev_q   <= 1'b0;
      deb_cnt_q   <= '0;
      in_data_q   <= '0;
      disp_q      <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      db_prev_q   <= db_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      in_data_q   <= in_data_d;
      disp_q      <= disp_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_data    = in_data_q;
  assign bus.in_ack     = (state_q == ACK);
  assign bus.busy       = (state_q != IDLE);
  assign bus.disp_value = disp_q;
  assign bus.out_count  = out_count_q;

endmodule

// File: tb/tb_io_responder.sv
// Scoreboard bench for io_responder: stimulus queues expected acks and OUT results,
// independent monitors pop and compare whenever the DUT presents them.
module tb_io_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_responder_if bus();

  io_responder #(.DEB_CYCLES(4)) dut (
    .Clock   (clk),
    .n_reset (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] ack_q[$];
  logic [23:0] out_q[$];
  logic        out_seen = 1'b0;
  logic [15:0] m_disp = '0;
  logic [7:0]  m_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) out_seen <= bus.out_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Ack monitor: every in_ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.in_ack === 1'b1) begin
      $display("ack cyc=%0d in_data=%h", cyc, bus.in_data);
      if (ack_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=%h required=no_ack", bus.in_data);
      end else begin
        check("ack_data", bus.in_data, ack_q.pop_front());
      end
    end
  end

  // OUT monitor: registers are compared the cycle after each sampled strobe.
  always @(negedge clk) begin
    if (out_seen) begin
      if (out_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%h_%h required=none", bus.disp_value, bus.out_count);
      end else begin
        check("out_regs", 32'({bus.disp_value, bus.out_count}), 32'(out_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic out_write(input logic [31:0] d);
    bus.out_req  = 1'b1;
    bus.out_data = d;
    m_disp = d[15:0];
    m_cnt  = m_cnt + 8'd1;
    out_q.push_back({m_disp, m_cnt});
    @(negedge clk);
    bus.out_req = 1'b0;
  endtask

  task automatic wait_ack(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.in_ack === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=none required=ack_within_%0d", max);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int at;
    int t0;
    bus.in_req   = 1'b0;
    bus.out_req  = 1'b0;
    bus.out_data = '0;
    bus.button   = 1'b0;
    bus.switches = '0;
    tick(2);
    check("rst_in_ack", 32'(bus.in_ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_in_data", bus.in_data, 32'd0);
    check("rst_disp", 32'(bus.disp_value), 32'd0);
    check("rst_count", 32'(bus.out_count), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic accept with sign extension and exact latency.
    bus.switches = 16'h8001;
    bus.in_req = 1'b1;
    tick(3);
    check("busy_armed", 32'(bus.busy), 32'd1);
    ack_q.push_back(32'hFFFF8001);
    t0 = cyc;
    bus.button = 1'b1;
    wait_ack(20, at);
    check("ack_latency", 32'(at), 32'(t0 + 7));
    tick(4);
    check("busy_done_held", 32'(bus.busy), 32'd1);
    bus.in_req = 1'b0;
    check("busy_before_drop", 32'(bus.busy), 32'd1);
    tick(1);
    check("busy_after_drop", 32'(bus.busy), 32'd0);
    bus.button = 1'b0;
    tick(10);

    // Three-cycle glitch rejected, four stable cycles accepted.
    bus.switches = 16'h1234;
    bus.in_req = 1'b1;
    tick(3);
    bus.button = 1'b1;
    tick(3);
    bus.button = 1'b0;
    tick(12);
    check("glitch_busy", 32'(bus.busy), 32'd1);
    check("glitch_in_data_hold", bus.in_data, 32'hFFFF8001);
    bus.switches = 16'h7FFE;
    ack_q.push_back(32'h00007FFE);
    t0 = cyc;
    bus.button = 1'b1;
    tick(4);
    bus.button = 1'b0;
    wait_ack(10, at);
    check("pulse4_latency", 32'(at), 32'(t0 + 7));
    bus.in_req = 1'b0;
    tick(10);

    // Button held before the request: must release then press.
    bus.button = 1'b1;
    tick(10);
    bus.switches = 16'hABCD;
    bus.in_req = 1'b1;
    tick(10);
    check("held_busy", 32'(bus.busy), 32'd1);
    bus.button = 1'b0;
    tick(4);
    ack_q.push_back(32'hFFFFABCD);
    t0 = cyc;
    bus.button = 1'b1;
    wait_ack(20, at);
    check("held_latency", 32'(at), 32'(t0 + 7));
    bus.in_req = 1'b0;
    bus.button = 1'b0;
    tick(10);

    // Abort in WAIT_PRESS, later press must be ignored.
    bus.switches = 16'h5555;
    bus.in_req = 1'b1;
    tick(3);
    bus.in_req = 1'b0;
    tick(2);
    check("abort_busy", 32'(bus.busy), 32'd0);
    bus.button = 1'b1;
    tick(10);
    check("abort_busy_press", 32'(bus.busy), 32'd0);
    check("abort_in_data", bus.in_data, 32'hFFFFABCD);
    bus.button = 1'b0;
    tick(10);

    // 256 OUT writes wrap the counter back to zero.
    for (int i = 0; i < 256; i++) out_write(32'h0001_1234);
    tick(1);
    check("wrap_disp", 32'(bus.disp_value), 32'h1234);
    check("wrap_count", 32'(bus.out_count), 32'd0);
    out_write(32'hFFFF_00A5);
    tick(1);

    // OUT strobe in the same cycle as in_ack.
    bus.switches = 16'h0F0F;
    ack_q.push_back(32'h00000F0F);
    bus.in_req = 1'b1;
    tick(3);
    bus.button = 1'b1;
    wait_ack(20, at);
    out_write(32'hBEEF_CAFE);
    check("coinc_disp", 32'(bus.disp_value), 32'hCAFE);
    check("coinc_count", 32'(bus.out_count), 32'd2);
    check("coinc_in_data", bus.in_data, 32'h00000F0F);
    bus.in_req = 1'b0;
    bus.button = 1'b0;
    tick(10);

    // Reset asserted during the ACK cycle.
    bus.switches = 16'h8000;
    ack_q.push_back(32'hFFFF8000);
    bus.in_req = 1'b1;
    tick(3);
    bus.button = 1'b1;
    wait_ack(20, at);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ack", 32'(bus.in_ack), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_in_data", bus.in_data, 32'd0);
    check("mid_rst_disp", 32'(bus.disp_value), 32'd0);
    check("mid_rst_count", 32'(bus.out_count), 32'd0);
    m_disp = '0;
    m_cnt  = '0;
    bus.button = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_rearm", 32'(bus.busy), 32'd1);
    tick(6);
    check("post_rst_busy", 32'(bus.busy), 32'd1);
    bus.in_req = 1'b0;
    tick(2);
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    tick(2);

    check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    check("out_queue_empty", 32'(out_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
